pts_tx_ctrl: RTL and testbench
==============================

Name: pts_tx_ctrl

Overview:
- Transmit controller sitting directly upstream of the 8-bit MSB-first parallel-to-serial shift register (idle-high, fills with 1s on shift).
- Accepts bytes over a valid/ready handshake into a one-entry holding buffer.
- Pulses the register's load_enable and shift_enable so each bit is held on the serial line for exactly CLKS_PER_BIT cycles.
- Inserts a configurable idle-high gap between bytes.

Parameters:
- NUM_BITS, 8: word width; must equal the shift register's NUM_BITS; must be at least 2.
- CLKS_PER_BIT, 4: clock cycles per serial bit; must be at least 1.
- IDLE_GAP, 2: idle-high cycles inserted between consecutive words; 0 means back-to-back.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- tx_data  in  NUM_BITS  word to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  controller can accept a word this cycle.
- sr_load_enable  out  1  one-cycle load pulse to the shift register.
- sr_shift_enable  out  1  one-cycle shift pulse to the shift register.
- sr_parallel_in  out  NUM_BITS  word driven to the shift register's parallel_in.
- busy  out  1  a transmission or gap is in progress.
- word_done  out  1  one-cycle pulse when the last bit period of a word ends.

Behaviour:
- Reset (async, n_rst=0): state IDLE; buffer empty; buf_data = all ones; timer = 0; bit_cnt = 0.
  - sr_load_enable=0, sr_shift_enable=0, word_done=0, busy=0, tx_ready=1, sr_parallel_in=all ones.
  - Reset mid-word drops the word and any buffered word. The shift register resets to all-ones, so the line is high.
- Buffer:
  - Accept when tx_valid && tx_ready: buf_data <= tx_data, buf_valid <= 1.
  - tx_ready = !buf_valid || load_pulse.
  - Consume and accept in the same cycle leaves buf_valid=1 holding the new word.
  - sr_parallel_in = buf_data (combinational).
- load_pulse = sr_load_enable. It clears buf_valid unless a simultaneous accept occurs.
- FSM states: IDLE, SHIFT, GAP. busy = (state != IDLE).
- IDLE:
  - If buf_valid: assert sr_load_enable, set timer=0 and bit_cnt=0, go to SHIFT.
  - Load asserts the cycle after the accepting edge (1-cycle latency from an idle accept).
- SHIFT:
  - timer increments each cycle, 0..CLKS_PER_BIT-1. A boundary is timer == CLKS_PER_BIT-1; at a boundary the timer returns to 0.
  - Boundary with bit_cnt < NUM_BITS-1: sr_shift_enable=1, bit_cnt++.
  - Boundary with bit_cnt == NUM_BITS-1: word_done=1, then:
    - IDLE_GAP==0 and buf_valid: sr_load_enable=1 (no shift), bit_cnt=0, stay in SHIFT.
    - Otherwise: sr_shift_enable=1 (line returns high), then go to GAP if IDLE_GAP>0, else go to IDLE.
  - Each bit therefore lasts exactly CLKS_PER_BIT cycles. A word lasts NUM_BITS*CLKS_PER_BIT cycles from the load edge.
- GAP:
  - timer counts 0..IDLE_GAP-1.
  - At IDLE_GAP-1: if buf_valid, sr_load_enable=1 and go to SHIFT (timer=0, bit_cnt=0); else go to IDLE.
  - Line is high for exactly IDLE_GAP cycles between queued words.
- sr_load_enable and sr_shift_enable are never asserted in the same cycle.
- CLKS_PER_BIT==1: a boundary occurs every SHIFT cycle.
- Counter widths:
  - timer: max($clog2(max(CLKS_PER_BIT, IDLE_GAP)), 1).
  - bit_cnt: $clog2(NUM_BITS).
  - No wrap beyond the terminal values.
- tx_valid held with a full buffer and no consume: no accept, data not lost (upstream holds).

Decomposition:
- Package pts_tx_pkg: state enum typedef (IDLE, SHIFT, GAP) and a timer-width function/constant.
- Sub-module tx_bit_timer: a loadable up-counter with clear, enable and a terminal-value input, producing a boundary flag. It is used for both bit timing and gap timing.

Test Plan (defaults unless noted; serial line observed through an instantiated shift register):
1. Reset mid-operation, then release.
   - Expect: all outputs at reset values, tx_ready=1, line high.
2. Single word 0xA5 accepted in IDLE.
   - sr_load_enable the next cycle with sr_parallel_in=0xA5.
   - 8 sr_shift_enable pulses spaced 4 cycles apart.
   - Line shows 1,0,1,0,0,1,0,1 at 4 cycles each, then high.
   - word_done once, 32 cycles after the load edge; busy is then high for 2 more cycles (GAP).
3. IDLE_GAP=0, words 0x3C then 0xC3 queued.
   - 16 contiguous bit periods with no high gap.
   - At the 8th boundary: load only, no shift.
   - word_done twice, 32 cycles apart.
4. IDLE_GAP=2, three words offered continuously.
   - tx_ready low while the buffer is full.
   - Accept and consume occur in the same cycle at load.
   - Line high exactly 2 cycles between words; no word lost or duplicated.
5. CLKS_PER_BIT=1, word 0x81.
   - Shift every cycle; word done 8 cycles after load.
   - Line shows 1,0,0,0,0,0,0,1.
6. Reset asserted after 3 bits of 0xF0 with 0x0F buffered.
   - Immediate return to reset values; both words dropped.
   - A subsequent 0x55 transmits correctly.

Source files
------------

// File: rtl/pts_tx_pkg.sv
// Shared types and sizing helpers for the parallel-to-serial transmit controller.
package pts_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } tx_state_e;

    // One timer serves both bit timing and gap timing, so size it for the larger span.
    function automatic int unsigned timer_width(input int unsigned clks_per_bit,
                                                input int unsigned idle_gap);
        int unsigned span;
        span = (clks_per_bit > idle_gap) ? clks_per_bit : idle_gap;
        return (span > 1) ? int'($clog2(span)) : 1;
    endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Up-counter that wraps at a programmable terminal value and flags the terminal cycle.
module tx_bit_timer #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal,
    output logic             boundary_c
);

    logic [WIDTH-1:0] count;

    assign boundary_c = (count == terminal);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= boundary_c ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pts_tx_ctrl.sv
// Transmit controller driving load/shift pulses of an MSB-first, idle-high
// parallel-to-serial shift register from a one-entry valid/ready buffer.
module pts_tx_ctrl
    import pts_tx_pkg::*;
#(
    parameter int unsigned NUM_BITS     = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned IDLE_GAP     = 2
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NUM_BITS-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic                sr_load_enable,
    output logic                sr_shift_enable,
    output logic [NUM_BITS-1:0] sr_parallel_in,
    output logic                busy,
    output logic                word_done
);

    localparam int unsigned TIMER_W = timer_width(CLKS_PER_BIT, IDLE_GAP);
    localparam int unsigned CNT_W   = $clog2(NUM_BITS);

    localparam logic [TIMER_W-1:0] BIT_TERM = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [TIMER_W-1:0] GAP_TERM = TIMER_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(NUM_BITS - 1);

    tx_state_e           state;
    logic                buf_valid;
    logic [NUM_BITS-1:0] buf_data;
    logic [CNT_W-1:0]    bit_cnt;
    logic                accept;
    logic                timer_clear;
    logic                timer_enable;
    logic [TIMER_W-1:0]  timer_term;
    logic                boundary;

    // The buffer frees up in the same cycle the shift register takes its word.
    assign tx_ready       = !buf_valid || sr_load_enable;
    assign accept         = tx_valid && tx_ready;
    assign sr_parallel_in = buf_data;
    assign busy           = (state != IDLE);

    // Timer is held at zero while idle and wraps to zero at every boundary, so
    // each state transition lands on a fresh count.
    assign timer_clear  = (state == IDLE);
    assign timer_enable = (state != IDLE);
    assign timer_term   = (state == GAP) ? GAP_TERM : BIT_TERM;

    tx_bit_timer #(
        .WIDTH(TIMER_W)
    ) u_timer (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear     (timer_clear),
        .enable    (timer_enable),
        .terminal  (timer_term),
        .boundary_c(boundary)
    );

    // One-entry holding buffer; an accept during a load keeps it full with the new word.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            buf_valid <= 1'b0;
            buf_data  <= '1;
        end else if (accept) begin
            buf_valid <= 1'b1;
            buf_data  <= tx_data;
        end else if (sr_load_enable) begin
            buf_valid <= 1'b0;
        end
    end

    // Pulses are registered one cycle ahead of the shift register edge they act on.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state           <= IDLE;
            bit_cnt         <= '0;
            sr_load_enable  <= 1'b0;
            sr_shift_enable <= 1'b0;
            word_done       <= 1'b0;
        end else begin
            sr_load_enable  <= 1'b0;
            sr_shift_enable <= 1'b0;
            word_done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (buf_valid) begin
                        sr_load_enable <= 1'b1;
                        bit_cnt        <= '0;
                        state          <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (boundary) begin
                        if (bit_cnt != LAST_BIT) begin
                            sr_shift_enable <= 1'b1;
                            bit_cnt         <= bit_cnt + CNT_W'(1);
                        end else begin
                            word_done <= 1'b1;
                            bit_cnt   <= '0;
                            if (IDLE_GAP == 0 && buf_valid) begin
                                // Back-to-back: reload replaces the final shift.
                                sr_load_enable <= 1'b1;
                            end else begin
                                sr_shift_enable <= 1'b1;
                                state           <= (IDLE_GAP > 0) ? GAP : IDLE;
                            end
                        end
                    end
                end
                GAP: begin
                    if (boundary) begin
                        if (buf_valid) begin
                            sr_load_enable <= 1'b1;
                            bit_cnt        <= '0;
                            state          <= SHIFT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pts_tx_ctrl.sv
// Scoreboard bench for pts_tx_ctrl: three parameterisations each feeding a
// behavioural idle-high MSB-first shift register whose serial line is checked bit by bit.
module tb_pts_tx_ctrl;

    localparam int LOAD_TMO = 200;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    logic       valid [3];
    logic [7:0] data  [3];
    logic       ready [3];
    logic       load  [3];
    logic       shift [3];
    logic       done  [3];
    logic       busy  [3];
    logic [7:0] pin   [3];

    logic [7:0] sr0, sr1, sr2;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] sb_q[$];
    logic       saw_full;
    logic       saw_simul;

    pts_tx_ctrl #(.NUM_BITS(8), .CLKS_PER_BIT(4), .IDLE_GAP(2)) u_dut0 (
        .clk(clk), .n_rst(n_rst), .tx_data(data[0]), .tx_valid(valid[0]), .tx_ready(ready[0]),
        .sr_load_enable(load[0]), .sr_shift_enable(shift[0]), .sr_parallel_in(pin[0]),
        .busy(busy[0]), .word_done(done[0]));

    pts_tx_ctrl #(.NUM_BITS(8), .CLKS_PER_BIT(4), .IDLE_GAP(0)) u_dut1 (
        .clk(clk), .n_rst(n_rst), .tx_data(data[1]), .tx_valid(valid[1]), .tx_ready(ready[1]),
        .sr_load_enable(load[1]), .sr_shift_enable(shift[1]), .sr_parallel_in(pin[1]),
        .busy(busy[1]), .word_done(done[1]));

    pts_tx_ctrl #(.NUM_BITS(8), .CLKS_PER_BIT(1), .IDLE_GAP(2)) u_dut2 (
        .clk(clk), .n_rst(n_rst), .tx_data(data[2]), .tx_valid(valid[2]), .tx_ready(ready[2]),
        .sr_load_enable(load[2]), .sr_shift_enable(shift[2]), .sr_parallel_in(pin[2]),
        .busy(busy[2]), .word_done(done[2]));

    // Downstream shift registers: reset to ones, load wins, shift fills with ones.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)        sr0 <= '1;
        else if (load[0])  sr0 <= pin[0];
        else if (shift[0]) sr0 <= {sr0[6:0], 1'b1};
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)        sr1 <= '1;
        else if (load[1])  sr1 <= pin[1];
        else if (shift[1]) sr1 <= {sr1[6:0], 1'b1};
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)        sr2 <= '1;
        else if (load[2])  sr2 <= pin[2];
        else if (shift[2]) sr2 <= {sr2[6:0], 1'b1};
    end

    always_ff @(posedge clk) cyc <= cyc + 1;

    function automatic logic line_of(input int d);
        case (d)
            0:       return sr0[7];
            1:       return sr1[7];
            default: return sr2[7];
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Offer one word from the current negedge until accepted; push it to the scoreboard.
    task automatic send(input int d, input logic [7:0] b);
        int t = 0;
        valid[d] = 1'b1;
        data[d]  = b;
        while (!ready[d] && t < LOAD_TMO) begin
            saw_full = 1'b1;
            @(negedge clk);
            t++;
        end
        check("accept", 32'(ready[d]), 32'd1);
        if (load[d]) saw_simul = 1'b1;
        sb_q.push_back(b);
        @(negedge clk);
        valid[d] = 1'b0;
    endtask

    // Follow nwords transmissions: data at load, every serial cycle, pulses, and gap.
    task automatic mon_words(input int d, input int cpb, input int gap, input int nwords,
                             output int first_wait);
        int         t;
        int         last_load;
        int         nsh;
        logic       clash;
        logic       early_done;
        logic [7:0] exp;
        first_wait = -1;
        last_load  = 0;
        for (int w = 0; w < nwords; w++) begin
            t = 0;
            while (!load[d] && t < LOAD_TMO) begin
                @(negedge clk);
                t++;
            end
            if (w == 0) first_wait = t;
            check("load_seen", 32'(load[d]), 32'd1);
            if (!load[d]) return;
            check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() == 0) return;
            exp = sb_q.pop_front();
            check("load_data", 32'(pin[d]), 32'(exp));
            if (w > 0) check("load_spacing", 32'(cyc - last_load), 32'(8 * cpb + gap));
            last_load  = cyc;
            nsh        = 0;
            clash      = 1'b0;
            early_done = 1'b0;
            for (int j = 0; j < 8 * cpb; j++) begin
                @(negedge clk);
                check("line_bit", 32'(line_of(d)), 32'(exp[7 - j / cpb]));
                if (shift[d]) nsh++;
                if (shift[d] && load[d]) clash = 1'b1;
                if (j < 8 * cpb - 1 && done[d]) early_done = 1'b1;
            end
            check("word_done", 32'(done[d]), 32'd1);
            check("early_done", 32'(early_done), 32'd0);
            check("shift_count", 32'(nsh), (gap == 0 && w < nwords - 1) ? 32'd7 : 32'd8);
            check("no_clash", 32'(clash), 32'd0);
            if (gap > 0) begin
                @(negedge clk);
                check("gap_line", 32'(line_of(d)), 32'd1);
                check("gap_busy", 32'(busy[d]), 32'd1);
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_load"},  32'(load[0]),  32'd0);
        check({tag, "_shift"}, 32'(shift[0]), 32'd0);
        check({tag, "_done"},  32'(done[0]),  32'd0);
        check({tag, "_busy"},  32'(busy[0]),  32'd0);
        check({tag, "_ready"}, 32'(ready[0]), 32'd1);
        check({tag, "_pin"},   32'(pin[0]),   32'hFF);
        check({tag, "_line"},  32'(line_of(0)), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int   fw;
        int   nsh;
        int   t;
        logic seen;
        n_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid[i] = 1'b0;
            data[i]  = 8'h00;
        end
        saw_full  = 1'b0;
        saw_simul = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        // 1: reset in the middle of a word, then release
        send(0, 8'h5A);
        repeat (10) @(negedge clk);
        n_rst = 1'b0;
        #1;
        check_reset_vals("rst1");
        sb_q.delete();
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check_reset_vals("rst1_rel");

        // 2: single word; load lands on the second negedge after valid is raised
        fork
            send(0, 8'hA5);
            mon_words(0, 4, 2, 1, fw);
        join
        check("load_latency", 32'(fw), 32'd2);
        @(negedge clk);
        check("idle_busy", 32'(busy[0]), 32'd0);
        check("idle_ready", 32'(ready[0]), 32'd1);
        check("idle_line", 32'(line_of(0)), 32'd1);

        // 3: back-to-back words with no gap
        fork
            begin send(1, 8'h3C); send(1, 8'hC3); end
            mon_words(1, 4, 0, 2, fw);
        join
        check("sb_drained3", 32'(sb_q.size()), 32'd0);
        repeat (4) @(negedge clk);

        // 4: three words offered continuously with a 2-cycle gap
        saw_full  = 1'b0;
        saw_simul = 1'b0;
        fork
            begin send(0, 8'hA7); send(0, 8'h5E); send(0, 8'hC9); end
            mon_words(0, 4, 2, 3, fw);
        join
        check("ready_low_when_full", 32'(saw_full), 32'd1);
        check("accept_at_load", 32'(saw_simul), 32'd1);
        check("sb_drained4", 32'(sb_q.size()), 32'd0);
        repeat (4) @(negedge clk);

        // 5: one clock per bit
        fork
            send(2, 8'h81);
            mon_words(2, 1, 2, 1, fw);
        join
        repeat (4) @(negedge clk);

        // 6: reset after three bits with a second word buffered
        send(0, 8'hF0);
        send(0, 8'h0F);
        check("buffered_full", 32'(ready[0]), 32'd0);
        nsh = 0;
        t   = 0;
        while (nsh < 3 && t < LOAD_TMO) begin
            @(negedge clk);
            if (shift[0]) nsh++;
            t++;
        end
        check("three_shifts", 32'(nsh), 32'd3);
        check("busy_pre_rst", 32'(busy[0]), 32'd1);
        n_rst = 1'b0;
        #1;
        check_reset_vals("rst6");
        sb_q.delete();
        @(negedge clk);
        n_rst = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (load[0] || busy[0] || !line_of(0)) seen = 1'b1;
        end
        check("words_dropped", 32'(seen), 32'd0);
        fork
            send(0, 8'h55);
            mon_words(0, 4, 2, 1, fw);
        join
        check("sb_drained6", 32'(sb_q.size()), 32'd0);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
